register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 32, number of entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the read ports.
REQ-005 Derived AW = clog2(DEPTH); NB = WIDTH/8.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 wstrb  input  NB  byte write mask; bit i gates wdata[8i+7:8i].
REQ-012 raddr1  input  AW  read port 1 address.
REQ-013 rdata1  output  WIDTH  read port 1 data.
REQ-014 raddr2  input  AW  read port 2 address.
REQ-015 rdata2  output  WIDTH  read port 2 data.
REQ-016 wr_count  output  AW+1  number of distinct entries written since last reset.

Function
REQ-017 Reads SHALL be combinational: rdataN = entry[raddrN] in the same cycle, no clock latency.
REQ-018 Write SHALL occur at the rising edge when we=1 and rst=0; only bytes with wstrb[i]=1 change, the rest hold.
REQ-019 we=1 with wstrb=0 SHALL change no entry and SHALL NOT affect wr_count.
REQ-020 we=0 SHALL leave all entries unchanged regardless of waddr/wdata/wstrb.
REQ-021 ZERO_REG=1: rdataN SHALL be 0 whenever raddrN=0; writes to address 0 SHALL be discarded and not counted.
REQ-022 BYPASS=1: if we=1, rst=0 and raddrN=waddr (not a discarded address-0 write), rdataN SHALL present the merged value (wstrb bytes from wdata, other bytes from the stored entry) in that cycle.
REQ-023 BYPASS=0: rdataN SHALL show the pre-write stored value until the edge, new value afterwards.
REQ-024 Both read ports SHALL be independent; raddr1=raddr2 SHALL return identical data.
REQ-025 Per-entry written flag SHALL be set on first effective write (we=1, wstrb!=0, address not discarded); wr_count SHALL equal the number of set flags.
REQ-026 Rewriting an already-flagged entry SHALL NOT increment wr_count; wr_count saturates naturally at DEPTH (or DEPTH-1 with ZERO_REG=1).
REQ-027 Address range is exactly 0..DEPTH-1; no out-of-range condition exists.

Reset
REQ-028 rst=1 at a rising edge SHALL clear every entry to 0, every written flag, and wr_count to 0, taking priority over any simultaneous write.
REQ-029 While rst=1, BYPASS forwarding SHALL be suppressed; rdataN SHALL show stored contents (0 after the first reset edge).
REQ-030 Reset asserted mid-sequence SHALL discard all prior writes; the first write after rst deasserts SHALL behave as on a fresh block.
REQ-031 Contents before the first reset edge are undefined; the bench SHALL apply reset before checking.

Verification
REQ-032 Reset then read all addresses on both ports -> all 0, wr_count=0.
REQ-033 Write 0x0000001A to addr 5, wstrb=0xF; next cycle raddr1=5 -> 0x0000001A, wr_count=1; write 0x0000001C to addr 5 -> reads 0x0000001C, wr_count stays 1.
REQ-034 Addr 7 holds 0x11223344; write 0xAABBCCDD with wstrb=0b0101 -> reads 0x11BB33DD.
REQ-035 BYPASS=1: we=1, waddr=3, wdata=0xDEADBEEF, raddr1=raddr2=3 -> both ports show 0xDEADBEEF in the same cycle; BYPASS=0 -> old value, then 0xDEADBEEF after the edge.
REQ-036 ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> rdata reads 0, wr_count unchanged.
REQ-037 Write addrs 1,2,3 (wr_count=3), then rst=1 with simultaneous we=1 to addr 4 -> all entries 0, wr_count=0, addr 4 reads 0.

Source files
------------

// File: rtl/register_file.sv
// Multi-ported register file: two combinational read ports, one byte-masked write
// port, optional hard-wired zero entry, optional write-to-read forwarding, write tracking.
module register_file #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(DEPTH),
   localparam int NB      = WIDTH / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [NB-1:0]     wstrb,
   input  logic [AW-1:0]     raddr1,
   output logic [WIDTH-1:0]  rdata1,
   input  logic [AW-1:0]     raddr2,
   output logic [WIDTH-1:0]  rdata2,
   output logic [AW:0]       wr_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_written;
   logic [AW:0]      r_wr_count;

   logic             w_discard;
   logic             w_fwd_ok;
   logic             w_eff_write;
   logic [WIDTH-1:0] w_merged;

   assign w_discard   = ZERO_REG && (waddr == '0);
   assign w_fwd_ok    = we && !rst && !w_discard;
   assign w_eff_write = w_fwd_ok && (wstrb != '0);

   // Stored entry with the strobed bytes replaced; this is both the value written
   // at the edge and the value forwarded to a matching read port in this cycle.
   always_comb begin
      w_merged = r_mem[waddr];
      for (int b = 0; b < NB; b++) begin
         if (wstrb[b]) begin
            w_merged[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_written  <= '0;
         r_wr_count <= '0;
      end else if (w_eff_write) begin
         r_mem[waddr] <= w_merged;
         if (!r_written[waddr]) begin
            r_written[waddr] <= 1'b1;
            r_wr_count       <= r_wr_count + (AW+1)'(1);
         end
      end
   end

   always_comb begin
      if (ZERO_REG && (raddr1 == '0)) begin
         rdata1 = '0;
      end else if (BYPASS && w_fwd_ok && (raddr1 == waddr)) begin
         rdata1 = w_merged;
      end else begin
         rdata1 = r_mem[raddr1];
      end
   end

   always_comb begin
      if (ZERO_REG && (raddr2 == '0)) begin
         rdata2 = '0;
      end else if (BYPASS && w_fwd_ok && (raddr2 == waddr)) begin
         rdata2 = w_merged;
      end else begin
         rdata2 = r_mem[raddr2];
      end
   end

   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: a forwarding instance and a non-forwarding instance share stimulus;
// every check compares against hand-computed values.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
   logic [5:0]  wr_count_b, wr_count_n;

   int n_tests = 0;
   int n_fail  = 0;

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
      .raddr1(raddr1), .rdata1(rdata1_b), .raddr2(raddr2), .rdata2(rdata2_b),
      .wr_count(wr_count_b)
   );

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nobyp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
      .raddr1(raddr1), .rdata1(rdata1_n), .raddr2(raddr2), .rdata2(rdata2_n),
      .wr_count(wr_count_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      we = w; waddr = a; wdata = d; wstrb = s;
      #1;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      raddr1 = a1; raddr2 = a2;
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
      raddr1 = '0; raddr2 = '0;
      tick();
      tick();

      // Still in reset: a write to addr 3 must not be forwarded
      drive(1'b1, 5'd3, 32'hCAFE_F00D, 4'hF);
      rd(5'd3, 5'd3);
      chk("rst_nofwd_r1", rdata1_b, 32'h0);
      chk("rst_nofwd_r2", rdata2_b, 32'h0);
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 4'h0);

      for (int a = 0; a < 32; a++) begin
         rd(5'(a), 5'(31 - a));
         chk("reset_r1", rdata1_b, 32'h0);
         chk("reset_r2", rdata2_b, 32'h0);
      end
      chk("reset_count", 32'(wr_count_b), 32'd0);

      // Full-word write, forwarded in the same cycle on the bypass instance only
      drive(1'b1, 5'd5, 32'h0000_001A, 4'hF);
      rd(5'd5, 5'd5);
      chk("w5_fwd", rdata1_b, 32'h0000_001A);
      chk("w5_nofwd_old", rdata1_n, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("w5_read", rdata1_b, 32'h0000_001A);
      chk("w5_read_n", rdata1_n, 32'h0000_001A);
      chk("w5_count", 32'(wr_count_b), 32'd1);

      drive(1'b1, 5'd5, 32'h0000_001C, 4'hF);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("rw5_read", rdata1_b, 32'h0000_001C);
      chk("rw5_count", 32'(wr_count_b), 32'd1);

      // Byte-masked merge
      drive(1'b1, 5'd7, 32'h1122_3344, 4'hF);
      tick();
      drive(1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
      rd(5'd7, 5'd7);
      chk("strb_fwd", rdata2_b, 32'h11BB_33DD);
      chk("strb_nofwd_old", rdata2_n, 32'h1122_3344);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("strb_read", rdata1_b, 32'h11BB_33DD);
      chk("strb_count", 32'(wr_count_b), 32'd2);

      // we=1 with no strobes: nothing changes, not counted
      drive(1'b1, 5'd9, 32'hFFFF_FFFF, 4'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      rd(5'd9, 5'd7);
      chk("nostrb_data", rdata1_b, 32'h0);
      chk("nostrb_count", 32'(wr_count_b), 32'd2);

      // we=0 ignores address/data/strobes
      drive(1'b0, 5'd5, 32'hFFFF_FFFF, 4'hF);
      tick();
      rd(5'd5, 5'd5);
      chk("we0_hold", rdata1_b, 32'h0000_001C);

      // Same-address forwarding on both ports
      drive(1'b1, 5'd3, 32'hDEAD_BEEF, 4'hF);
      rd(5'd3, 5'd3);
      chk("byp_r1", rdata1_b, 32'hDEAD_BEEF);
      chk("byp_r2", rdata2_b, 32'hDEAD_BEEF);
      chk("nobyp_r1_old", rdata1_n, 32'h0);
      chk("nobyp_r2_old", rdata2_n, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("nobyp_r1_new", rdata1_n, 32'hDEAD_BEEF);
      chk("nobyp_r2_new", rdata2_n, 32'hDEAD_BEEF);
      chk("byp_count", 32'(wr_count_b), 32'd3);
      chk("nobyp_count", 32'(wr_count_n), 32'd3);

      // Partial forward only on the port that matches
      drive(1'b1, 5'd7, 32'h0000_00EE, 4'b0001);
      rd(5'd5, 5'd7);
      chk("pfwd_other", rdata1_b, 32'h0000_001C);
      chk("pfwd_match", rdata2_b, 32'h11BB_33EE);
      chk("pfwd_nobyp", rdata2_n, 32'h11BB_33DD);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("pfwd_after", rdata2_n, 32'h11BB_33EE);
      chk("pfwd_count", 32'(wr_count_b), 32'd3);

      // Entry 0 is hard-wired zero
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
      rd(5'd0, 5'd0);
      chk("zero_fwd_r1", rdata1_b, 32'h0);
      chk("zero_fwd_r2", rdata2_b, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("zero_read", rdata1_b, 32'h0);
      chk("zero_count", 32'(wr_count_b), 32'd3);

      // Last entry
      drive(1'b1, 5'd31, 32'h8765_4321, 4'hF);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      rd(5'd31, 5'd3);
      chk("top_read", rdata1_b, 32'h8765_4321);
      chk("top_other", rdata2_b, 32'hDEAD_BEEF);
      chk("top_count", 32'(wr_count_b), 32'd4);

      // Fresh reset, three writes, then reset with a simultaneous write
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 5'd1, 32'h0000_0001, 4'hF); tick();
      drive(1'b1, 5'd2, 32'h0000_0002, 4'hF); tick();
      drive(1'b1, 5'd3, 32'h0000_0003, 4'hF); tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      chk("pre_rst_count", 32'(wr_count_b), 32'd3);
      rd(5'd2, 5'd5);
      chk("pre_rst_r1", rdata1_b, 32'h0000_0002);
      chk("pre_rst_r2_cleared", rdata2_b, 32'h0);

      rst = 1'b1;
      drive(1'b1, 5'd4, 32'h1234_5678, 4'hF);
      rd(5'd4, 5'd1);
      chk("rstw_nofwd", rdata1_b, 32'h0);
      chk("rstw_stored", rdata2_b, 32'h0000_0001);
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      for (int a = 1; a <= 4; a++) begin
         rd(5'(a), 5'(a));
         chk("rstw_clear", rdata1_b, 32'h0);
      end
      chk("rstw_count", 32'(wr_count_b), 32'd0);
      chk("rstw_count_n", 32'(wr_count_n), 32'd0);

      drive(1'b1, 5'd4, 32'h0000_0055, 4'hF);
      tick();
      drive(1'b0, 5'd0, 32'h0, 4'h0);
      rd(5'd4, 5'd4);
      chk("fresh_read", rdata2_b, 32'h0000_0055);
      chk("fresh_count", 32'(wr_count_b), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
